// File: rtl/cid_to_gcid_pipe_if.sv
// Request/result bundle for the local-to-global cell ID converter.
// The slave modport is the converter; the master modport is the dispatch
// side, which drives requests and consumes results.
interface cid_to_gcid_pipe_if #(
    parameter int CELL_ID_WIDTH        = 3,
    parameter int GLOBAL_CELL_ID_WIDTH = 3,
    parameter int CELL_FOLD_ID_WIDTH   = 1,
    parameter int TAG_WIDTH            = 8
);
    // request side
    logic                              i_valid;
    logic                              o_ready;
    logic [3*CELL_ID_WIDTH-1:0]        i_cid;
    logic [CELL_FOLD_ID_WIDTH-1:0]     i_fold_id;
    logic [5:0]                        i_offset;
    logic [TAG_WIDTH-1:0]              i_tag;

    // result side
    logic                              o_valid;
    logic                              i_ready;
    logic [3*GLOBAL_CELL_ID_WIDTH-1:0] o_gcid;
    logic [2:0]                        o_wrap_pos;
    logic [2:0]                        o_wrap_neg;
    logic                              o_err;
    logic [TAG_WIDTH-1:0]              o_tag;

    modport master (
        output i_valid, i_cid, i_fold_id, i_offset, i_tag, i_ready,
        input  o_ready, o_valid, o_gcid, o_wrap_pos, o_wrap_neg, o_err, o_tag
    );

    modport slave (
        input  i_valid, i_cid, i_fold_id, i_offset, i_tag, i_ready,
        output o_ready, o_valid, o_gcid, o_wrap_pos, o_wrap_neg, o_err, o_tag
    );
endinterface

// File: rtl/cid_to_gcid_pipe.sv
// Two-stage, fold-aware local-to-global cell ID converter.
// Stage 1 adds the per-fold global base, the local cell ID and the neighbour
// offset per axis, and flags illegal requests. Stage 2 applies periodic
// wrap-around per axis and reports which axes wrapped and in which direction.
// Both stages use valid/ready; a stalled result holds all output fields.
module cid_to_gcid_pipe #(
    parameter int CELL_ID_WIDTH        = 3,
    parameter int GLOBAL_CELL_ID_WIDTH = 3,
    parameter int NUM_CELL_FOLDS       = 2,
    parameter int CELL_FOLD_ID_WIDTH   = 1,
    parameter int GCELL_X [NUM_CELL_FOLDS] = '{0, 1},
    parameter int GCELL_Y [NUM_CELL_FOLDS] = '{0, 1},
    parameter int GCELL_Z [NUM_CELL_FOLDS] = '{0, 1},
    parameter int X_GDIM               = 3,
    parameter int Y_GDIM               = 3,
    parameter int Z_GDIM               = 3,
    parameter int TAG_WIDTH            = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    cid_to_gcid_pipe_if.slave    bus
);

    localparam int CW = CELL_ID_WIDTH;
    localparam int GW = GLOBAL_CELL_ID_WIDTH;
    // two extra bits: one for the carry of base+cid+offset, one for sign
    localparam int SW = GLOBAL_CELL_ID_WIDTH + 2;

    typedef logic signed [SW-1:0] sum_t;

    // axis index 0 = x, 1 = y, 2 = z, matching the {z,y,x} packing
    localparam sum_t GDIM [3] = '{sum_t'(X_GDIM), sum_t'(Y_GDIM), sum_t'(Z_GDIM)};

    // ------------------------------------------------------------------
    // handshake
    // ------------------------------------------------------------------
    logic s1_valid;
    logic s2_valid;
    logic s1_load;
    logic s2_load;
    logic accept;

    assign s2_load     = !s2_valid || bus.i_ready;
    assign s1_load     = !s1_valid || s2_load;
    assign bus.o_ready = s1_load;
    assign accept      = bus.i_valid && s1_load;

    // ------------------------------------------------------------------
    // stage 1: base select, per-axis sum and error detection
    // ------------------------------------------------------------------
    sum_t        base_v   [3];
    sum_t        cid_v    [3];
    sum_t        off_v    [3];
    sum_t        home_v   [3];
    sum_t        sum_d    [3];
    logic [1:0]  off_raw  [3];
    logic        fold_hit;
    logic        err_d;

    // Fold lookup is a compare against every legal fold rather than an
    // array index, so a fold ID beyond NUM_CELL_FOLDS simply misses.
    always_comb begin
        fold_hit = 1'b0;
        for (int a = 0; a < 3; a++) begin
            base_v[a] = '0;
        end
        for (int f = 0; f < NUM_CELL_FOLDS; f++) begin
            if (bus.i_fold_id == CELL_FOLD_ID_WIDTH'(f)) begin
                fold_hit  = 1'b1;
                base_v[0] = sum_t'(GCELL_X[f]);
                base_v[1] = sum_t'(GCELL_Y[f]);
                base_v[2] = sum_t'(GCELL_Z[f]);
            end
        end
    end

    // Per-axis sum; the home cell (base+cid) must already be inside the
    // global grid, otherwise one wrap would not be enough.
    always_comb begin
        err_d = !fold_hit;
        for (int a = 0; a < 3; a++) begin
            off_raw[a] = bus.i_offset[a*2 +: 2];
            cid_v[a]   = sum_t'(bus.i_cid[a*CW +: CW]);
            off_v[a]   = sum_t'(signed'(off_raw[a]));
            home_v[a]  = base_v[a] + cid_v[a];
            sum_d[a]   = home_v[a] + off_v[a];
            if (home_v[a] >= GDIM[a]) begin
                err_d = 1'b1;
            end
            if (off_raw[a] == 2'b10) begin
                err_d = 1'b1;
            end
        end
    end

    sum_t                 s1_sum [3];
    logic                 s1_err;
    logic [TAG_WIDTH-1:0] s1_tag;

    // Stage 1 register; data only moves on an accepted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_tag   <= '0;
            for (int a = 0; a < 3; a++) begin
                s1_sum[a] <= '0;
            end
        end else if (s1_load) begin
            s1_valid <= bus.i_valid;
            if (accept) begin
                s1_err <= err_d;
                s1_tag <= bus.i_tag;
                for (int a = 0; a < 3; a++) begin
                    s1_sum[a] <= sum_d[a];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // stage 2: periodic wrap per axis
    // ------------------------------------------------------------------
    sum_t              adj_v [3];
    logic [3*GW-1:0]   gcid_d;
    logic [2:0]        wrap_pos_d;
    logic [2:0]        wrap_neg_d;

    // An erroneous request still produces a result, but with a zero ID
    // and no wrap flags so downstream never acts on garbage coordinates.
    always_comb begin
        gcid_d     = '0;
        wrap_pos_d = '0;
        wrap_neg_d = '0;
        for (int a = 0; a < 3; a++) begin
            adj_v[a] = s1_sum[a];
            if (s1_sum[a] >= GDIM[a]) begin
                adj_v[a]      = s1_sum[a] - GDIM[a];
                wrap_pos_d[a] = 1'b1;
            end else if (s1_sum[a] < sum_t'(0)) begin
                adj_v[a]      = s1_sum[a] + GDIM[a];
                wrap_neg_d[a] = 1'b1;
            end
            gcid_d[a*GW +: GW] = GW'(adj_v[a]);
        end
        if (s1_err) begin
            gcid_d     = '0;
            wrap_pos_d = '0;
            wrap_neg_d = '0;
        end
    end

    logic [3*GW-1:0]      s2_gcid;
    logic [2:0]           s2_wrap_pos;
    logic [2:0]           s2_wrap_neg;
    logic                 s2_err;
    logic [TAG_WIDTH-1:0] s2_tag;

    // Stage 2 register; holds its contents while the result is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid    <= 1'b0;
            s2_gcid     <= '0;
            s2_wrap_pos <= '0;
            s2_wrap_neg <= '0;
            s2_err      <= 1'b0;
            s2_tag      <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_gcid     <= gcid_d;
                s2_wrap_pos <= wrap_pos_d;
                s2_wrap_neg <= wrap_neg_d;
                s2_err      <= s1_err;
                s2_tag      <= s1_tag;
            end
        end
    end

    assign bus.o_valid    = s2_valid;
    assign bus.o_gcid     = s2_gcid;
    assign bus.o_wrap_pos = s2_wrap_pos;
    assign bus.o_wrap_neg = s2_wrap_neg;
    assign bus.o_err      = s2_err;
    assign bus.o_tag      = s2_tag;

endmodule

// File: doc/cid_to_gcid_pipe.md
Name: cid_to_gcid_pipe

Overview:
Pipelined, fold-aware converter from local cell ID to global cell ID. Each output carries the global cell ID of the home cell, or of a neighbour cell when a per-axis offset is applied. Periodic wrap-around is applied per axis, and per-axis wrap flags are reported for position correction downstream.
Sits between the local cell/particle dispatch logic and the inter-FPGA routing table. Supports multiple cell folds per FPGA and valid/ready backpressure.

Parameters:
CELL_ID_WIDTH, 3, width of one local cell-ID axis field
GLOBAL_CELL_ID_WIDTH, 3, width of one global cell-ID axis field
NUM_CELL_FOLDS, 2, number of cell folds mapped onto this FPGA
CELL_FOLD_ID_WIDTH, 1, width of fold select; must satisfy 2^CELL_FOLD_ID_WIDTH >= NUM_CELL_FOLDS
GCELL_X / GCELL_Y / GCELL_Z, '{0,1} / '{0,1} / '{0,1}, per-fold global base of each axis
X_GDIM / Y_GDIM / Z_GDIM, 3 / 3 / 3, global cell count per axis, used as the periodic modulus
TAG_WIDTH, 8, width of the opaque tag carried alongside each request

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
i_valid  in  1  request valid
o_ready  out  1  converter can accept a request this cycle
i_cid  in  3*CELL_ID_WIDTH  packed {z,y,x} local cell ID
i_fold_id  in  CELL_FOLD_ID_WIDTH  fold select
i_offset  in  6  packed {z,y,x} 2-bit two's-complement neighbour offset per axis; legal values -1, 0, +1
i_tag  in  TAG_WIDTH  opaque tag, returned unchanged
o_valid  out  1  result valid
i_ready  in  1  downstream accepts the result
o_gcid  out  3*GLOBAL_CELL_ID_WIDTH  packed {z,y,x} global cell ID
o_wrap_pos  out  3  {z,y,x}: axis sum was >= GDIM and GDIM was subtracted
o_wrap_neg  out  3  {z,y,x}: axis sum was < 0 and GDIM was added
o_err  out  1  fold out of range, base+cid >= GDIM on any axis, or offset = -2 (2'b10)
o_tag  out  TAG_WIDTH  tag of the result

Behaviour:
- Reset (asynchronous, active-high): both stage valid registers clear to 0. All data registers clear to 0, so o_gcid, flags, o_err and o_tag are 0. o_valid is 0. o_ready is 1 on the first clk after rst deasserts.
- A request transfers when i_valid && o_ready. A result transfers when o_valid && i_ready.
- Pipeline: 2 register stages. Latency is exactly 2 cycles from accept to o_valid with no backpressure. Throughput is 1 per cycle.
- Stage 1:
  - Select per-fold base from the GCELL arrays by i_fold_id.
  - Per axis, form a signed sum = base + cid + sext(offset), width GLOBAL_CELL_ID_WIDTH+2.
  - Compute the error term.
  - Register sum, error and tag.
- Stage 2, per axis:
  - sum >= GDIM: gcid = sum - GDIM, wrap_pos = 1.
  - sum < 0: gcid = sum + GDIM, wrap_neg = 1.
  - Otherwise gcid = sum, both flags 0.
  - At most one wrap is needed because base+cid is in [0, GDIM-1] for legal input.
- Error case:
  - o_err = 1 and o_gcid is forced to 0. Flags are forced to 0.
  - The result is still delivered in order; it is never dropped.
- Stall rule: stage2 loads when !s2_valid || i_ready. Stage1 loads when !s1_valid || stage2 loads. o_ready = !s1_valid || stage2 loads.
- Under backpressure, o_gcid, flags, o_err and o_tag hold stable while o_valid && !i_ready. No request is lost or duplicated.
- Simultaneous accept and output transfer on a full pipe: both occur in the same cycle with no bubble.
- Reset mid-operation: in-flight results are discarded. o_valid drops immediately (asynchronous).
- Outputs are registered only; there is no combinational path from i_* to o_*, except o_ready from i_ready.

Test Plan:
- Reset then single request: cid {1,1,1}, fold 1, offset {0,0,0}, tag 0x5A -> 2 cycles later o_valid=1, o_gcid {2,2,2}, no flags, o_tag 0x5A.
- Positive wrap: cid {1,0,1}, fold 1, offset x=+1, y=0, z=+1 -> o_gcid {0,1,0} (x: 1+1+1=3 -> 0; y: 1+0+0=1; z: 1+1+1=3 -> 0), o_wrap_pos {1,0,1}, o_wrap_neg 0.
- Negative wrap: cid {0,0,0}, fold 0, offset {-1,-1,-1} -> o_gcid {2,2,2}, o_wrap_neg 3'b111.
- Error: fold 0, cid x=3 (base 0 + 3 >= GDIM 3) -> o_err=1, o_gcid 0, flags 0. The following legal request is unaffected.
- Backpressure: stream 8 back-to-back requests while i_ready toggles 1,0,0,1 -> all 8 results in order with matching tags. Outputs are stable while stalled. o_ready=0 exactly when both stages are full and i_ready=0.
- Mid-stream reset: assert rst with 2 requests in flight -> o_valid=0 immediately. No stale result appears after reset release.
